rs_latch_exerciser: RTL

- Self-test driver for the active-low R-S latch lab block on the EGO1 board. Replaces the two slide switches with a sequencer.
- Drives active-low r_n/s_n into a latch under test and reads back Q and /Q.
- Steps a fixed truth-table sequence and compares each readback against the expected value.
- Reports progress and pass/fail on the 16 LEDs.

---
 rtl/rs_latch_exerciser_if.sv | 26 ++
 rtl/rs_latch_exerciser.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/rs_latch_exerciser_if.sv
`default_nettype none
// ============================================================================
// Module   : rs_latch_exerciser_if
// Purpose  : Latch drive/readback and LED bundle between the exerciser and
//            the board side (start button, latch under test, LED bank).
// Revision : 1.0  initial release
// ============================================================================
interface rs_latch_exerciser_if;
    logic        start;
    logic        q_in;
    logic        qn_in;
    logic        r_n;
    logic        s_n;
    logic [15:0] led_pin;

    modport master (
        output start, q_in, qn_in,
        input  r_n, s_n, led_pin
    );

    modport slave (
        input  start, q_in, qn_in,
        output r_n, s_n, led_pin
    );
endinterface
`default_nettype wire

// File: rtl/rs_latch_exerciser.sv
`default_nettype none
// ============================================================================
// Module   : rs_latch_exerciser
// Purpose  : Steps an active-low R-S latch through a truth-table sequence,
//            checks Q and /Q after each vector and reports on 16 LEDs.
//            Optional macro RS_FORBIDDEN_STEP_EN adds the forbidden 00 step
//            plus a recovery step.
// Revision : 1.0  initial release
// ============================================================================
module rs_latch_exerciser #(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rs_latch_exerciser_if.slave  bus
);

`ifdef RS_FORBIDDEN_STEP_EN
    localparam logic [3:0] c_LAST_STEP = 4'd7;
`else
    localparam logic [3:0] c_LAST_STEP = 4'd5;
`endif

    localparam logic [15:0] c_SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_APPLY  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_FAIL   = 3'd5;

    // Returns {r_n, s_n, expected Q, expected /Q}; unused steps fall back to hold.
    function automatic logic [3:0] f_vector(input logic [3:0] step);
        logic [3:0] v;
        case (step)
            4'd0:    v = 4'b10_10;
            4'd1:    v = 4'b11_10;
            4'd2:    v = 4'b01_01;
            4'd3:    v = 4'b11_01;
            4'd4:    v = 4'b10_10;
            4'd5:    v = 4'b11_10;
`ifdef RS_FORBIDDEN_STEP_EN
            4'd6:    v = 4'b00_11;
            4'd7:    v = 4'b10_10;
`endif
            default: v = 4'b11_10;
        endcase
        return v;
    endfunction

    logic        r_start_meta, r_start_sync, r_start_prev;
    logic        r_q_meta, r_q_sync;
    logic        r_qn_meta, r_qn_sync;
    logic [2:0]  r_state;
    logic [3:0]  r_step;
    logic [15:0] r_cnt;
    logic        r_rn, r_sn;
    logic [15:0] r_led;

    logic [2:0]  w_next;
    logic        w_start_edge;
    logic [3:0]  w_vec;
    logic        w_match;
    logic        w_busy, w_pass, w_fail;

    assign w_start_edge = r_start_sync & ~r_start_prev;
    assign w_vec        = f_vector(r_step);
    // Both bits compared, so Q == /Q outside the forbidden step is a mismatch.
    assign w_match      = ({r_q_sync, r_qn_sync} == w_vec[1:0]);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (w_start_edge) w_next = S_APPLY;
            end
            S_APPLY:  w_next = S_SETTLE;
            S_SETTLE: begin
                if (r_cnt == 16'd0) w_next = S_CHECK;
            end
            S_CHECK: begin
                if (!w_match)                  w_next = S_FAIL;
                else if (r_step == c_LAST_STEP) w_next = S_DONE;
                else                            w_next = S_APPLY;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        w_busy = 1'b0;
        w_pass = 1'b0;
        w_fail = 1'b0;
        case (r_state)
            S_APPLY, S_SETTLE, S_CHECK: w_busy = 1'b1;
            S_DONE:                     w_pass = 1'b1;
            S_FAIL:                     w_fail = 1'b1;
            default:                    w_busy = 1'b0;
        endcase
    end

    // Synchronizers, sequencing datapath and LED register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_meta <= 1'b0;
            r_start_sync <= 1'b0;
            r_start_prev <= 1'b0;
            r_q_meta     <= 1'b0;
            r_q_sync     <= 1'b0;
            r_qn_meta    <= 1'b0;
            r_qn_sync    <= 1'b0;
            r_step       <= 4'd0;
            r_cnt        <= 16'd0;
            r_rn         <= 1'b1;
            r_sn         <= 1'b1;
            r_led        <= 16'd0;
        end else begin
            r_start_meta <= bus.start;
            r_start_sync <= r_start_meta;
            r_start_prev <= r_start_sync;
            r_q_meta     <= bus.q_in;
            r_q_sync     <= r_q_meta;
            r_qn_meta    <= bus.qn_in;
            r_qn_sync    <= r_qn_meta;

            case (r_state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (w_start_edge) r_step <= 4'd0;
                end
                S_APPLY: begin
                    r_rn  <= w_vec[3];
                    r_sn  <= w_vec[2];
                    r_cnt <= c_SETTLE_LOAD;
                end
                S_SETTLE: begin
                    if (r_cnt != 16'd0) r_cnt <= r_cnt - 16'd1;
                end
                S_CHECK: begin
                    // Step freezes on failure so the LEDs show the failing index.
                    if (w_next == S_APPLY) begin
                        r_step <= r_step + 4'd1;
                    end else begin
                        r_rn <= 1'b1;
                        r_sn <= 1'b1;
                    end
                end
                default: r_step <= r_step;
            endcase

            r_led <= {5'd0, w_fail, w_pass, w_busy, r_step,
                      r_sn, r_rn, r_q_sync, r_qn_sync};
        end
    end

    assign bus.r_n     = r_rn;
    assign bus.s_n     = r_sn;
    assign bus.led_pin = r_led;

endmodule
`default_nettype wire
